// File: rtl/mem_pkg.sv
// Shared memory-port definitions for the data-side write buffer.
// Holds the access-size encodings and the posted-write entry layout.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo_mem.sv
// Entry storage for the write buffer: one synchronous write port and
// an asynchronous read port addressed by the head pointer.
module wb_fifo_mem
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  wb_entry_t        wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output wb_entry_t        rdata_o
);

    wb_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/d_write_buffer.sv
// Posted-write FIFO between the data cache and the sram-like AXI bridge.
// Writes complete upstream immediately; reads pass through once the FIFO drains.
module d_write_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_req,
    input  logic        up_wr,
    input  logic [1:0]  up_size,
    input  logic [31:0] up_addr,
    input  logic [31:0] up_wdata,
    output logic [31:0] up_rdata,
    output logic        up_addr_ok,
    output logic        up_data_ok,
    output logic        dn_req,
    output logic        dn_wr,
    output logic [1:0]  dn_size,
    output logic [31:0] dn_addr,
    output logic [31:0] dn_wdata,
    input  logic [31:0] dn_rdata,
    input  logic        dn_addr_ok,
    input  logic        dn_data_ok,
    output logic        wb_empty
);

    localparam int unsigned    PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN_A,
        DRAIN_D,
        RD_A,
        RD_D
    } wb_state_e;

    wb_state_e        state_q, state_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic      full;
    logic      in_rd;
    logic      push;
    logic      pop;
    wb_entry_t new_entry;
    wb_entry_t head;

    assign full  = (count_q == FULL_CNT);
    assign in_rd = (state_q == RD_A) || (state_q == RD_D);
    // A write presented while rst is high would be acknowledged and then lost.
    assign push  = up_req & up_wr & ~full & ~in_rd & ~rst;
    assign pop   = (state_q == DRAIN_D) & dn_data_ok;

    assign new_entry = '{addr: up_addr, size: up_size, wdata: up_wdata};

    wb_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i(new_entry),
        .raddr_i(rd_ptr_q),
        .rdata_o(head)
    );

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        up_addr_ok = push;
        up_data_ok = push;
        up_rdata   = '0;
        dn_req     = 1'b0;
        dn_wr      = 1'b0;
        dn_size    = '0;
        dn_addr    = '0;
        dn_wdata   = '0;

        case (state_q)
            IDLE: begin
                // count_d covers a write accepted this cycle into an empty FIFO.
                if (count_d != '0) begin
                    state_d = DRAIN_A;
                end else if (up_req & ~up_wr) begin
                    state_d = RD_A;
                end
            end
            DRAIN_A: begin
                dn_req   = 1'b1;
                dn_wr    = 1'b1;
                dn_size  = head.size;
                dn_addr  = head.addr;
                dn_wdata = head.wdata;
                if (dn_addr_ok) begin
                    state_d = DRAIN_D;
                end
            end
            DRAIN_D: begin
                if (dn_data_ok) begin
                    state_d = (count_d != '0) ? DRAIN_A : IDLE;
                end
            end
            RD_A: begin
                dn_req     = up_req;
                dn_size    = up_size;
                dn_addr    = up_addr;
                up_addr_ok = dn_addr_ok;
                if (dn_addr_ok) begin
                    state_d = RD_D;
                end
            end
            RD_D: begin
                up_data_ok = dn_data_ok;
                up_rdata   = dn_rdata;
                if (dn_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wb_empty = (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_d_write_buffer.sv
// Bench for d_write_buffer: transaction-level model of the posted-write queue,
// a delay-configurable bridge with its own memory, and directed timing cases.
module tb_d_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_req, up_wr;
    logic [1:0]  up_size;
    logic [31:0] up_addr, up_wdata, up_rdata;
    logic        up_addr_ok, up_data_ok;
    logic        dn_req, dn_wr;
    logic [1:0]  dn_size;
    logic [31:0] dn_addr, dn_wdata, dn_rdata;
    logic        dn_addr_ok, dn_data_ok;
    logic        wb_empty;

    d_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_req    (up_req),
        .up_wr     (up_wr),
        .up_size   (up_size),
        .up_addr   (up_addr),
        .up_wdata  (up_wdata),
        .up_rdata  (up_rdata),
        .up_addr_ok(up_addr_ok),
        .up_data_ok(up_data_ok),
        .dn_req    (dn_req),
        .dn_wr     (dn_wr),
        .dn_size   (dn_size),
        .dn_addr   (dn_addr),
        .dn_wdata  (dn_wdata),
        .dn_rdata  (dn_rdata),
        .dn_addr_ok(dn_addr_ok),
        .dn_data_ok(dn_data_ok),
        .wb_empty  (wb_empty)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Program-order memory (updated on upstream acceptance) vs bridge memory.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bmem    [logic [31:0]];
    bit          br_en;
    int          adly_cfg, ddly_cfg;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: queue of posted writes plus read/outstanding flags.
    initial begin : model
        logic [65:0] expq[$];
        logic [65:0] hd;
        bit          m_wait, m_rd, m_curwr, acc, ereq, rd_start;
        logic [31:0] m_rdexp;
        int          n;
        m_wait = 0; m_rd = 0; m_curwr = 0; m_rdexp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                expq.delete();
                m_wait = 0;
                m_rd   = 0;
            end else begin
                n    = expq.size();
                hd   = (n > 0) ? expq[0] : '0;
                acc  = up_req && up_wr && (n < DEPTH) && !m_rd;
                ereq = !m_wait && ((n > 0) || (m_rd && up_req));
                chk("up_addr_ok", up_addr_ok, acc || (m_rd && !m_wait && dn_addr_ok));
                chk("up_data_ok", up_data_ok, acc || (m_rd && m_wait && dn_data_ok));
                chk("up_rdata", up_rdata, (m_rd && m_wait) ? dn_rdata : 32'h0);
                chk("wb_empty", wb_empty, (n == 0) && !m_rd);
                chk("dn_req", dn_req, ereq);
                if (ereq && n > 0) begin
                    chk("dn_wr", dn_wr, 1);
                    chk("dn_addr", dn_addr, hd[65:34]);
                    chk("dn_size", dn_size, hd[33:32]);
                    chk("dn_wdata", dn_wdata, hd[31:0]);
                end else if (ereq) begin
                    chk("dn_rd_wr", dn_wr, 0);
                    chk("dn_rd_addr", dn_addr, up_addr);
                    chk("dn_rd_size", dn_size, up_size);
                end
                if (n == 0 && !m_rd) begin
                    chk("idle_dn_addr", dn_addr, 0);
                    chk("idle_dn_wdata", dn_wdata, 0);
                end
                if (m_rd && m_wait && dn_data_ok && br_en)
                    chk("rd_value", up_rdata, m_rdexp);

                rd_start = !m_rd && (n == 0) && up_req && !up_wr;
                if (ereq && dn_addr_ok) begin
                    m_wait  = 1;
                    m_curwr = (n > 0);
                end else if (m_wait && dn_data_ok) begin
                    m_wait = 0;
                    if (m_curwr) expq.delete(0);
                    else         m_rd = 0;
                end
                if (rd_start) begin
                    m_rd    = 1;
                    m_rdexp = ref_mem.exists(up_addr) ? ref_mem[up_addr] : 32'h0;
                end
                if (acc) begin
                    expq.push_back({up_addr, up_size, up_wdata});
                    ref_mem[up_addr] = up_wdata;
                end
            end
        end
    end

    // Bridge responder; negative delay config means random 0..3 cycles.
    initial begin : bridge
        int          ph, acnt, dcnt;
        logic [31:0] ca, cd;
        logic        cw;
        ph = 0; acnt = 0; dcnt = 0; ca = '0; cd = '0; cw = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!br_en) begin
                ph = 0;
            end else begin
                dn_addr_ok = 1'b0;
                dn_data_ok = 1'b0;
                dn_rdata   = $urandom;
                if (rst) begin
                    ph = 0;
                end else if (ph == 0) begin
                    if (!dn_req) begin
                        acnt = (adly_cfg < 0) ? int'($urandom_range(3, 0)) : adly_cfg;
                    end else if (acnt == 0) begin
                        dn_addr_ok = 1'b1;
                        ca = dn_addr; cd = dn_wdata; cw = dn_wr;
                        ph = 1;
                        dcnt = (ddly_cfg < 0) ? int'($urandom_range(3, 0)) : ddly_cfg;
                    end else begin
                        acnt--;
                    end
                end else if (dcnt == 0) begin
                    dn_data_ok = 1'b1;
                    if (cw) bmem[ca] = cd;
                    else    dn_rdata = bmem.exists(ca) ? bmem[ca] : 32'h0;
                    ph = 0;
                    acnt = (adly_cfg < 0) ? int'($urandom_range(3, 0)) : adly_cfg;
                end else begin
                    dcnt--;
                end
            end
        end
    end

    task automatic wr_req(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                          output int acc);
        bit done;
        done = 0;
        acc  = -1;
        up_req = 1'b1; up_wr = 1'b1; up_addr = a; up_size = s; up_wdata = d;
        for (int unsigned k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (up_addr_ok) begin
                done = 1;
                acc  = cyc;
            end
            step();
        end
        up_req = 1'b0; up_wr = 1'b0; up_addr = '0; up_size = '0; up_wdata = '0;
        chk("wr_accepted", done, 1);
    endtask

    task automatic rd_req(input logic [31:0] a, output logic [31:0] data);
        bit done;
        done = 0;
        data = '0;
        up_req = 1'b1; up_wr = 1'b0; up_addr = a; up_size = 2'd2;
        for (int unsigned k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (up_addr_ok) done = 1;
            step();
        end
        up_req = 1'b0; up_addr = '0; up_size = '0;
        chk("rd_accepted", done, 1);
        done = 0;
        for (int unsigned k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (up_data_ok) begin
                done = 1;
                data = up_rdata;
            end
            step();
        end
        chk("rd_completed", done, 1);
    endtask

    task automatic wait_empty();
        bit done;
        done = 0;
        for (int unsigned k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            if (wb_empty) done = 1;
            step();
        end
        chk("drained", done, 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: run did not finish (%0d compared / %0d mismatched so far)",
                 n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : directed
        int          acc0, acc3, acc4, t;
        logic [31:0] rd, a;
        rst = 1'b1; br_en = 0; adly_cfg = 0; ddly_cfg = 0;
        up_req = 0; up_wr = 0; up_size = '0; up_addr = '0; up_wdata = '0;
        dn_rdata = '0; dn_addr_ok = 0; dn_data_ok = 0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wb_empty", wb_empty, 1);
        chk("rst_dn_req", dn_req, 0);
        chk("rst_up_addr_ok", up_addr_ok, 0);
        chk("rst_up_data_ok", up_data_ok, 0);
        chk("rst_up_rdata", up_rdata, 0);

        // Single write, bridge acks promptly.
        step();
        up_req = 1; up_wr = 1; up_addr = 32'h1000; up_size = 2'd2; up_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_addr_ok", up_addr_ok, 1);
        chk("t1_data_ok", up_data_ok, 1);
        step();
        up_req = 0; up_wr = 0; up_addr = '0; up_size = '0; up_wdata = '0;
        #1 dn_addr_ok = 1;
        @(negedge clk);
        chk("t1_dn_req", dn_req, 1);
        chk("t1_dn_wr", dn_wr, 1);
        chk("t1_dn_addr", dn_addr, 32'h1000);
        chk("t1_dn_wdata", dn_wdata, 32'hDEADBEEF);
        step();
        #1 dn_addr_ok = 0; dn_data_ok = 1;
        @(negedge clk);
        chk("t1_busy", wb_empty, 0);
        step();
        #1 dn_data_ok = 0;
        @(negedge clk);
        chk("t1_empty_again", wb_empty, 1);

        // Read on empty FIFO: addr_ok at cycle 2, data at cycle 5.
        step();
        up_req = 1; up_wr = 0; up_addr = 32'h3000; up_size = 2'd2;
        @(negedge clk);
        chk("t4_c0_addr_ok", up_addr_ok, 0);
        step();
        @(negedge clk);
        chk("t4_c1_dn_req", dn_req, 1);
        chk("t4_c1_addr_ok", up_addr_ok, 0);
        step();
        #1 dn_addr_ok = 1;
        @(negedge clk);
        chk("t4_c2_addr_ok", up_addr_ok, 1);
        step();
        up_req = 0; up_addr = '0; up_size = '0;
        #1 dn_addr_ok = 0;
        @(negedge clk);
        chk("t4_c3_data_ok", up_data_ok, 0);
        step();
        @(negedge clk);
        chk("t4_c4_data_ok", up_data_ok, 0);
        step();
        #1 dn_data_ok = 1; dn_rdata = 32'hCAFE0000;
        @(negedge clk);
        chk("t4_c5_data_ok", up_data_ok, 1);
        chk("t4_c5_rdata", up_rdata, 32'hCAFE0000);
        step();
        #1 dn_data_ok = 0; dn_rdata = '0;
        @(negedge clk);
        chk("t4_done_empty", wb_empty, 1);

        // Reset while draining with three entries queued.
        step();
        up_req = 1; up_wr = 1; up_addr = 32'h5000; up_size = 2'd2; up_wdata = 32'h0A0A0A0A;
        @(negedge clk);
        chk("t6_w0_ok", up_addr_ok, 1);
        step();
        up_addr = 32'h5004; up_wdata = 32'h0B0B0B0B;
        #1 dn_addr_ok = 1;
        @(negedge clk);
        chk("t6_dn_head", dn_addr, 32'h5000);
        step();
        up_addr = 32'h5008; up_wdata = 32'h0C0C0C0C;
        #1 dn_addr_ok = 0;
        @(negedge clk);
        chk("t6_w2_ok", up_addr_ok, 1);
        step();
        up_req = 0; up_wr = 0; up_addr = '0; up_wdata = '0; up_size = '0;
        rst = 1;
        @(negedge clk);
        chk("t6_pre_rst_busy", wb_empty, 0);
        step();
        rst = 0;
        #1 dn_data_ok = 1;
        @(negedge clk);
        chk("t6_post_rst_empty", wb_empty, 1);
        chk("t6_post_rst_dn_req", dn_req, 0);
        step();
        #1 dn_data_ok = 0;
        @(negedge clk);
        chk("t6_late_ok_ignored", wb_empty, 1);
        chk("t6_late_dn_req", dn_req, 0);

        ref_mem.delete();
        bmem.delete();
        adly_cfg = 0; ddly_cfg = 10; br_en = 1;
        step();

        // Five back-to-back writes against a slow bridge.
        wr_req(32'h7000, 2'd2, 32'h70000000, acc0);
        wr_req(32'h7004, 2'd2, 32'h70000001, t);
        wr_req(32'h7008, 2'd2, 32'h70000002, t);
        wr_req(32'h700C, 2'd2, 32'h70000003, acc3);
        wr_req(32'h7010, 2'd2, 32'h70000004, acc4);
        chk("t2_4th_accept_delay", acc3 - acc0, 3);
        chk("t2_5th_accept_delay", acc4 - acc0, 13);
        wait_empty();
        chk("t2_last_mem", bmem.exists(32'h7010) ? bmem[32'h7010] : 32'hFFFFFFFF, 32'h70000004);

        // Write then read the same address.
        adly_cfg = 1; ddly_cfg = 2;
        wr_req(32'h2000, 2'd2, 32'h11223344, t);
        rd_req(32'h2000, rd);
        chk("t3_read_data", rd, 32'h11223344);
        wait_empty();

        // Nine writes with continuous draining exercise pointer wrap.
        adly_cfg = 0; ddly_cfg = 0;
        for (int i = 0; i < 9; i++)
            wr_req(32'h4000 + 32'(4 * i), 2'd2, 32'hA0000000 + 32'(i), t);
        wait_empty();
        for (int i = 0; i < 9; i++) begin
            a = 32'h4000 + 32'(4 * i);
            chk("t5_mem", bmem.exists(a) ? bmem[a] : 32'hFFFFFFFF, 32'hA0000000 + 32'(i));
        end

        // Random mix of writes and reads with random bridge latencies.
        adly_cfg = -1; ddly_cfg = -1;
        for (int i = 0; i < 250; i++) begin
            a = 32'h6000 + 32'(4 * $urandom_range(15, 0));
            if ($urandom_range(9, 0) < 7)
                wr_req(a, 2'($urandom_range(2, 0)), $urandom, t);
            else
                rd_req(a, rd);
            repeat ($urandom_range(2, 0)) step();
        end
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
